// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with blanking and tear-free double buffer
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module seg7_scan_driver #(
   parameter int DIGITS       = 8,
   parameter int BLANK_CYCLES = 16,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scan_clk,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_done
);

   localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int BLAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
   localparam int FW    = 6 * DIGITS;

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t              state, state_nxt;
   logic [IW-1:0]       idx, idx_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic                scan_prev, scan_rise;
   logic                boundary;
   logic [FW-1:0]       frame_in, staging, shadow, shadow_nxt;
   logic                pending, pending_nxt;
   logic [4*DIGITS-1:0] sh_data;
   logic [DIGITS-1:0]   sh_en, sh_dp;
   logic [3:0]          nib;
   logic [6:0]          hex;
   logic [DIGITS-1:0]   lz;
   logic [7:0]          seg_nxt;
   logic [DIGITS-1:0]   an_nxt;

   assign frame_in                 = {data, digit_en, dp};
   assign {sh_data, sh_en, sh_dp}  = shadow;
   assign scan_rise                = scan_clk & ~scan_prev;
   assign nib                      = sh_data[{idx, 2'b00} +: 4];

   always_comb begin
      hex = 7'h00;
      case (nib)
         4'h0: hex = 7'h3F;
         4'h1: hex = 7'h06;
         4'h2: hex = 7'h5B;
         4'h3: hex = 7'h4F;
         4'h4: hex = 7'h66;
         4'h5: hex = 7'h6D;
         4'h6: hex = 7'h7D;
         4'h7: hex = 7'h07;
         4'h8: hex = 7'h7F;
         4'h9: hex = 7'h6F;
         4'hA: hex = 7'h77;
         4'hB: hex = 7'h7C;
         4'hC: hex = 7'h39;
         4'hD: hex = 7'h5E;
         4'hE: hex = 7'h79;
         4'hF: hex = 7'h71;
         default: hex = 7'h00;
      endcase
   end

`ifdef SEG_LZ_BLANK_EN
   logic lz_zero;
   // Walk from the most significant digit down; a digit is a leading zero while
   // every nibble above and including it is zero and it carries no decimal point.
   always_comb begin
      lz      = '0;
      lz_zero = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         lz_zero = lz_zero & (sh_data[4*i +: 4] == 4'h0);
         lz[i]   = lz_zero & ~sh_dp[i];
      end
   end
`else
   assign lz = '0;
`endif

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      cnt_nxt     = '0;
      boundary    = 1'b0;
      shadow_nxt  = shadow;
      pending_nxt = pending;
      seg_nxt     = 8'h00;
      an_nxt      = '0;

      case (state)
         ST_BLANK: begin
            if (cnt == CW'(BLAST)) state_nxt = ST_SHOW;
            else                   cnt_nxt   = cnt + 1'b1;
         end
         ST_SHOW: begin
            if (scan_rise) begin
               state_nxt = ST_BLANK;
               boundary  = (idx == IW'(DIGITS - 1));
               idx_nxt   = boundary ? '0 : idx + 1'b1;
            end
         end
         default: state_nxt = ST_BLANK;
      endcase

      // Shadow only changes at the frame boundary; a load on that same cycle bypasses staging.
      if (boundary) begin
         if (load)         shadow_nxt = frame_in;
         else if (pending) shadow_nxt = staging;
         pending_nxt = 1'b0;
      end else if (load) begin
         pending_nxt = 1'b1;
      end

      // idx and shadow are stable whenever the next state is SHOW, so current values drive the registers.
      if (state_nxt == ST_SHOW) begin
         seg_nxt = {sh_dp[idx], hex};
         if (sh_en[idx] && !lz[idx]) an_nxt = DIGITS'(1) << idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_BLANK;
         idx        <= '0;
         cnt        <= '0;
         scan_prev  <= 1'b0;
         staging    <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         seg_out    <= {8{ACTIVE_LOW}};
         an_out     <= {DIGITS{ACTIVE_LOW}};
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         scan_prev  <= scan_clk;
         if (load) staging <= frame_in;
         shadow     <= shadow_nxt;
         pending    <= pending_nxt;
         seg_out    <= seg_nxt ^ {8{ACTIVE_LOW}};
         an_out     <= an_nxt ^ {DIGITS{ACTIVE_LOW}};
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst, scan_clk, load;
   logic [31:0] data;
   logic [7:0]  digit_en, dp;
   logic [7:0]  seg_out, an_out;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   always #5 clk = ~clk;

   seg7_scan_driver dut (
      .clk        (clk),
      .rst        (rst),
      .scan_clk   (scan_clk),
      .data       (data),
      .digit_en   (digit_en),
      .dp         (dp),
      .load       (load),
      .seg_out    (seg_out),
      .an_out     (an_out),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] segx(input int n);
      return ~hex_tab[n];
   endfunction

   function automatic logic [7:0] anx(input int d);
      return ~(8'h01 << d);
   endfunction

   // One 40-cycle scan period; optionally a second rise lands inside the blank gap,
   // and optionally a load is presented on the rise cycle itself.
   task automatic rise(input bit inject, input bit do_load, input logic [31:0] d,
                       input logic [7:0] en, input logic [7:0] p,
                       output int blank_len, output logic [7:0] an,
                       output logic [7:0] seg, output int fd);
      bit seen = 1'b0;
      blank_len = 0;
      fd        = 0;
      an        = 8'hFF;
      seg       = 8'hFF;
      @(negedge clk);
      scan_clk = 1'b1;
      if (do_load) begin
         load = 1'b1; data = d; digit_en = en; dp = p;
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         load = 1'b0;
         if (frame_done) fd++;
         if (!seen) begin
            if (an_out == 8'hFF && seg_out == 8'hFF) blank_len++;
            else begin
               seen = 1'b1; an = an_out; seg = seg_out;
            end
         end
         if (inject && c == 1) scan_clk = 1'b0;
         if (inject && c == 3) scan_clk = 1'b1;
         if (c == 19) scan_clk = 1'b0;
      end
   endtask

   initial begin
      int         bl, fd, fdsum;
      logic [7:0] an, seg;

      rst = 1'b1; scan_clk = 1'b0; load = 1'b0; data = '0; digit_en = '0; dp = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_seg", seg_out, 8'hFF);
         check("rst_an", an_out, 8'hFF);
         check("rst_fd", frame_done, 1'b0);
         scan_clk = ~scan_clk;
      end
      @(negedge clk);
      rst = 1'b0; scan_clk = 1'b0;
      fdsum = 0;
      repeat (20) begin
         @(negedge clk);
         if (frame_done) fdsum++;
      end
      check("post_rst_an", an_out, 8'hFF);
      check("post_rst_fd", fdsum, 0);

      @(negedge clk);
      data = 32'h76543210; digit_en = 8'hFF; dp = 8'h00; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      fdsum = 0;
      for (int i = 0; i < 8; i++) begin
         rise(1'b0, 1'b0, '0, '0, '0, bl, an, seg, fd);
         fdsum += fd;
      end
      check("prime_fd", fdsum, 1);
      check("d0_an", an_out, 8'hFE);
      check("d0_seg", seg_out, segx(0));

      for (int d = 1; d < 8; d++) begin
         rise(d == 2, 1'b0, '0, '0, '0, bl, an, seg, fd);
         check("blank_len", bl, 16);
         check("scan_an", an, anx(d));
         check("scan_seg", seg, segx(d));
         check("scan_fd", fd, 0);
      end
      rise(1'b0, 1'b0, '0, '0, '0, bl, an, seg, fd);
      check("wrap_fd", fd, 1);
      check("wrap_an", an, 8'hFE);
      check("wrap_seg", seg, segx(0));
      for (int d = 1; d < 4; d++) rise(1'b0, 1'b0, '0, '0, '0, bl, an, seg, fd);

      @(negedge clk);
      data = 32'h12345678; load = 1'b1;
      @(negedge clk);
      data = 32'hFFFFFFFF;
      @(negedge clk);
      load = 1'b0;
      check("tear_an3", an_out, anx(3));
      check("tear_seg3", seg_out, segx(3));
      for (int d = 4; d < 8; d++) begin
         rise(1'b0, 1'b0, '0, '0, '0, bl, an, seg, fd);
         check("tear_an", an, anx(d));
         check("tear_seg", seg, segx(d));
      end
      rise(1'b0, 1'b0, '0, '0, '0, bl, an, seg, fd);
      check("new_fd", fd, 1);
      check("new_an0", an, 8'hFE);
      check("new_seg0", seg, segx(15));
      for (int d = 1; d < 8; d++) begin
         rise(1'b0, 1'b0, '0, '0, '0, bl, an, seg, fd);
         check("new_seg", seg, segx(15));
      end

      rise(1'b0, 1'b1, 32'h9876543C, 8'hFD, 8'h01, bl, an, seg, fd);
      check("byp_fd", fd, 1);
      check("byp_an0", an, 8'hFE);
      check("byp_seg0_dp", seg, 8'h46);
      rise(1'b0, 1'b0, '0, '0, '0, bl, an, seg, fd);
      check("dis_an1", an, 8'hFF);
      check("dis_seg1", seg, segx(3));
      rise(1'b0, 1'b0, '0, '0, '0, bl, an, seg, fd);
      check("byp_an2", an, anx(2));
      check("byp_seg2", seg, segx(4));

`ifdef SEG_LZ_BLANK_EN
      begin
         logic [7:0] lz_an [8];
         lz_an = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'hFF};
         @(negedge clk);
         data = 32'h00000305; digit_en = 8'hFF; dp = 8'h20; load = 1'b1;
         @(negedge clk);
         load = 1'b0;
         for (int d = 3; d < 9; d++) rise(1'b0, 1'b0, '0, '0, '0, bl, an, seg, fd);
         check("lz_an0", an_out, lz_an[0]);
         for (int d = 1; d < 8; d++) begin
            rise(1'b0, 1'b0, '0, '0, '0, bl, an, seg, fd);
            check("lz_an", an, lz_an[d]);
            if (d == 5) check("lz_seg5", seg, 8'h40);
         end
      end
`endif

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_seg", seg_out, 8'hFF);
      check("mid_rst_an", an_out, 8'hFF);
      check("mid_rst_fd", frame_done, 1'b0);
      fdsum = 0;
      repeat (30) begin
         @(negedge clk);
         if (frame_done) fdsum++;
      end
      check("mid_rst_nofd", fdsum, 0);
      check("mid_rst_show_an", an_out, 8'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
